// File: rtl/t_ev_rx_if.sv
// rtl/t_ev_rx_if.sv - toggle-event receiver link: toggle line, event handshake, pending count, overflow
interface t_ev_rx_if #(
   parameter int CNT_W = 4
);
   logic             tgl_in;
   logic             evt_valid;
   logic             evt_ready;
   logic [CNT_W-1:0] evt_cnt;
   logic             ovf;
   logic             ovf_clr;

   modport master (
      output tgl_in, evt_ready, ovf_clr,
      input  evt_valid, evt_cnt, ovf
   );

   modport slave (
      input  tgl_in, evt_ready, ovf_clr,
      output evt_valid, evt_cnt, ovf
   );
endinterface

// File: rtl/t_ev_rx.sv
// rtl/t_ev_rx.sv - toggle-event receiver: level changes become events in a saturating pending counter
// Optional macro T_EV_RX_SYNC_EN: route tgl_in through a 2-flop synchroniser before edge detection.
module t_ev_rx #(
   parameter int CNT_W = 4
) (
   input  logic         clk,
   input  logic         rst,
   t_ev_rx_if.slave     bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic {
      ST_UNARMED = 1'b0,
      ST_ARMED   = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic             tgl_s;
   logic             tgl_q, tgl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             det;
   logic             pop;
   logic             ovf_set;

`ifdef T_EV_RX_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], bus.tgl_in};
      end
   end

   assign tgl_s = sync_q[1];
`else
   assign tgl_s = bus.tgl_in;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_UNARMED;
         tgl_q   <= 1'b0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgl_q   <= tgl_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // The arming edge only captures the line level, so a line already high at reset is not an event.
   always_comb begin
      state_d = ST_ARMED;
      tgl_d   = tgl_s;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      det     = (state_q == ST_ARMED) && (tgl_s != tgl_q);
      pop     = bus.evt_valid && bus.evt_ready;
      ovf_set = det && !pop && (cnt_q == CNT_MAX);

      if (det && !pop && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (!det && pop) begin
         cnt_d = cnt_q - CNT_ONE;
      end

      if (ovf_set) begin
         ovf_d = 1'b1;
      end else if (bus.ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   assign bus.evt_cnt   = cnt_q;
   assign bus.evt_valid = (cnt_q != '0);
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_t_ev_rx.sv
// tb/tb_t_ev_rx.sv - self-checking bench for t_ev_rx (default and T_EV_RX_SYNC_EN builds)
module tb_t_ev_rx;
   localparam int CNT_W = 4;
   localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef T_EV_RX_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   t_ev_rx_if #(.CNT_W(CNT_W)) bus ();

   t_ev_rx #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Reference: pending events as a plain integer, clamped at MAXC; loss marks overflow.
   int  m_cnt   = 0;
   bit  m_ovf   = 1'b0;
   bit  m_armed = 1'b0;
   bit  m_prev  = 1'b0;
   logic line;
   logic ev;
   logic take;
   int  nxt;

`ifdef T_EV_RX_SYNC_EN
   bit m_s0 = 1'b0;
   bit m_s1 = 1'b0;
   assign line = m_s1;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_s0 <= 1'b0;
         m_s1 <= 1'b0;
      end else begin
         m_s0 <= bus.tgl_in;
         m_s1 <= m_s0;
      end
   end
`else
   assign line = bus.tgl_in;
`endif

   assign ev   = m_armed && (line != m_prev);
   assign take = (m_cnt > 0) && bus.evt_ready;
   assign nxt  = m_cnt + int'(ev) - int'(take);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt   <= 0;
         m_ovf   <= 1'b0;
         m_armed <= 1'b0;
         m_prev  <= 1'b0;
      end else begin
         m_cnt   <= (nxt > MAXC) ? MAXC : nxt;
         m_ovf   <= (nxt > MAXC) || (m_ovf && !bus.ovf_clr);
         m_armed <= 1'b1;
         m_prev  <= line;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic flip();
      bus.tgl_in = ~bus.tgl_in;
   endtask

   task automatic settle();
      cyc(LAT);
   endtask

   task automatic lit(input string name, input int cnt, input int ovf);
      chk({name, "_cnt"}, int'(bus.evt_cnt), cnt);
      chk({name, "_valid"}, int'(bus.evt_valid), (cnt != 0) ? 1 : 0);
      chk({name, "_ovf"}, int'(bus.ovf), ovf);
   endtask

   initial begin
`ifdef T_EV_RX_SYNC_EN
      bus.tgl_in = 1'b0;
`else
      bus.tgl_in = 1'b1;
`endif
      bus.evt_ready = 1'b0;
      bus.ovf_clr   = 1'b0;

      fork
         begin
            cyc(3);
            chk_en = 1'b1;
            lit("in_reset", 0, 0);
            rst = 1'b0;
            cyc(3);
            lit("armed_idle", 0, 0);

            flip();
`ifdef T_EV_RX_SYNC_EN
            cyc(1);
            lit("sync_lat_n", 0, 0);
            cyc(1);
            lit("sync_lat_n1", 0, 0);
            cyc(1);
            lit("sync_lat_n2", 1, 0);
`else
            cyc(1);
            lit("lat_n", 1, 0);
`endif
            cyc(1);
            repeat (2) begin
               flip();
               cyc(2);
            end
            settle();
            lit("three_ev", 3, 0);
            bus.evt_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
               cyc(1);
               chk("drain_cnt", int'(bus.evt_cnt), 2 - i);
            end
            chk("drain_valid", int'(bus.evt_valid), 0);
            bus.evt_ready = 1'b0;

            repeat (5) begin
               flip();
               cyc(1);
            end
            settle();
            lit("five_ev", 5, 0);
            flip();
            cyc(LAT - 1);
            bus.evt_ready = 1'b1;
            cyc(1);
            bus.evt_ready = 1'b0;
            lit("det_pop", 5, 0);
            settle();
            lit("det_pop_settled", 5, 0);
            bus.evt_ready = 1'b1;
            cyc(5);
            bus.evt_ready = 1'b0;
            lit("drained", 0, 0);

            repeat (15) begin
               flip();
               cyc(1);
            end
            settle();
            lit("full", 15, 0);
            flip();
            cyc(1);
            settle();
            lit("ovf_16th", 15, 1);
            flip();
            cyc(1);
            settle();
            lit("ovf_17th", 15, 1);
            bus.ovf_clr = 1'b1;
            cyc(1);
            bus.ovf_clr = 1'b0;
            lit("ovf_clr", 15, 0);
            flip();
            cyc(LAT - 1);
            bus.ovf_clr = 1'b1;
            cyc(1);
            bus.ovf_clr = 1'b0;
            lit("ovf_set_wins", 15, 1);
            bus.ovf_clr = 1'b1;
            cyc(1);
            bus.ovf_clr = 1'b0;
            flip();
            cyc(LAT - 1);
            bus.evt_ready = 1'b1;
            cyc(1);
            bus.evt_ready = 1'b0;
            lit("det_pop_at_max", 15, 0);

            flip();
            cyc(1);
            settle();
            bus.evt_ready = 1'b1;
            cyc(8);
            bus.evt_ready = 1'b0;
            lit("pre_reset", 7, 1);
            #2;
            rst = 1'b1;
            bus.tgl_in = 1'b0;
            #1;
            lit("async_reset", 0, 0);
            cyc(2);
            rst = 1'b0;
            cyc(3);
            lit("rearmed", 0, 0);
            flip();
            cyc(1);
            settle();
            lit("after_reset_ev", 1, 0);
         end
         begin
            forever begin
               @(negedge clk);
               if (chk_en) begin
                  chk("cyc_cnt", int'(bus.evt_cnt), m_cnt);
                  chk("cyc_valid", int'(bus.evt_valid), (m_cnt != 0) ? 1 : 0);
                  chk("cyc_ovf", int'(bus.ovf), int'(m_ovf));
               end
            end
         end
         begin
            #1000000;
            n_fail++;
            $display("FAIL watchdog: got timeout, want stimulus completion at %0t", $time);
         end
      join_any
      disable fork;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
